updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
// PURPOSE
//   Parametrised FSM-controlled up/down counter: configurable width, terminal count (modulo),
//   wrap-or-saturate mode, synchronous load/clear, separate overflow/underflow pulses.
//   Next generation of the team's basic 4-bit up/down counter. Used as a general event/timer
//   counter in FSM-based control paths.
// PARAMETERS
//   COUNTER_WIDTH   8                   count register width, >= 2
//   MAX_COUNT       2**COUNTER_WIDTH-1  terminal value; count range is 0..MAX_COUNT
//   SATURATE        0                   0 = wrap at the bounds, 1 = hold at the bounds
//   PRESCALE_WIDTH  4                   prescaler divide-select width (COUNTER_PRESCALE_EN only)
// PORTS
//   clk       in   1               system clock, all logic on the rising edge
//   rst       in   1               synchronous, active-high reset
//   act       in   1               activate: 1 = run, 0 = idle/hold
//   up_dwn_n  in   1               direction: 1 = count up, 0 = count down
//   load      in   1               synchronous load of load_val
//   load_val  in   COUNTER_WIDTH   value to load
//   clr       in   1               synchronous clear of count to 0
//   presc     in   PRESCALE_WIDTH  step every presc+1 cycles (present only with COUNTER_PRESCALE_EN)
//   count     out  COUNTER_WIDTH   current count, registered
//   ovflow    out  1               1-cycle pulse: up-step attempted at MAX_COUNT
//   unflow    out  1               1-cycle pulse: down-step attempted at 0
//   state_o   out  2               current FSM state (debug)
// BEHAVIOUR
//   - Reset: state=IDLE, count=0, ovflow=0, unflow=0, prescaler=0.
//   - FSM, registered every cycle: act=0 -> IDLE; act=1 & up_dwn_n=1 -> UP; act=1 & up_dwn_n=0 -> DOWN.
//     Direct UP<->DOWN transitions are legal. Encoding: IDLE=2'b00, UP=2'b01, DOWN=2'b10.
//   - Latency: count steps on edges where the registered state is UP/DOWN, so the first step
//     lands on the 2nd edge after act rises. IDLE holds count.
//   - Priority per edge: rst > clr > load > step. clr/load act in any state. On a clr/load edge
//     no step occurs and ovflow/unflow = 0.
//   - Load clip: load_val > MAX_COUNT loads MAX_COUNT.
//   - Up step: count<MAX_COUNT -> count+1. At MAX_COUNT: wrap to 0 (SATURATE=0) or hold
//     (SATURATE=1); ovflow=1 for that cycle.
//   - Down step: count>0 -> count-1. At 0: wrap to MAX_COUNT (SATURATE=0) or hold (SATURATE=1);
//     unflow=1 for that cycle.
//   - Saturate mode: a flag re-pulses on every attempted step while the count is held at the bound.
//   - ovflow/unflow are registered, high only on the edge the boundary step is taken, and never
//     both high together.
//   - Reset mid-count: the next edge forces all reset values, regardless of act/load/clr.
// CONFIGURATION
//   COUNTER_PRESCALE_EN defined:
//     - presc port exists; a prescaler issues one step tick every presc+1 cycles in UP/DOWN.
//     - The prescaler clears in IDLE and on clr/load/rst. The first step lands presc+1 cycles
//       after entering UP/DOWN.
//     - A direction change does not clear the prescaler.
//   COUNTER_PRESCALE_EN undefined:
//     - No presc port; a step occurs on every UP/DOWN cycle (equivalent to presc=0).
// STRUCTURE
//   - Package counter_pkg: state localparams (IDLE/UP/DOWN), 2-bit state width constant.
//   - Sub-module counter_prescaler (clk, rst, clr, en, div, tick), instantiated only under
//     COUNTER_PRESCALE_EN.
//   - Top holds the FSM, count register and flag logic.
// TESTING
//   1. rst=1 for 2 cycles with act=1, load=1 -> count=0, state_o=00, ovflow=unflow=0.
//   2. W=4, MAX=15, SAT=0: load 14, act=1, up -> 15, then 0 with ovflow=1 for exactly one cycle, then 1.
//   3. W=4, MAX=9, SAT=0: load 1, down -> 0, then 9 with unflow=1 for one cycle; load_val=12 -> count=9.
//   4. SAT=1, MAX=9, count=9, up for 3 cycles -> count stays 9, ovflow=1 on each of the 3 cycles.
//   5. Counting up at 5: load=1 & clr=1 -> 0; next cycle up_dwn_n=0 -> state DOWN, next step underflows.
//   6. COUNTER_PRESCALE_EN, presc=3, up from 0 -> count 1,2,3 on cycles 4,8,12 after entering UP;
//      act=0 mid-period then act=1 -> prescaler restarts its full period.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared FSM state encoding for the up/down modulo counter
package counter_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } state_t;
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: issues one tick every div+1 enabled cycles, restarting when disabled or cleared
module counter_prescaler #(
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);
    logic [DIV_WIDTH-1:0] cnt;

    assign tick = en && (cnt == div);

    // cycle counter restarts on reset, clear, idle or after each tick
    always_ff @(posedge clk) begin
        if (rst || clr || !en || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: FSM-controlled modulo up/down counter with wrap/saturate and flag pulses
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int COUNTER_WIDTH  = 8,
    parameter int MAX_COUNT      = 2**COUNTER_WIDTH-1,
    parameter bit SATURATE       = 1'b0
`ifdef COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE_WIDTH = 4
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     act,
    input  logic                     up_dwn_n,
    input  logic                     load,
    input  logic [COUNTER_WIDTH-1:0] load_val,
    input  logic                     clr,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_WIDTH-1:0] presc,
`endif
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     ovflow,
    output logic                     unflow,
    output logic [STATE_W-1:0]       state_o
);
    localparam logic [COUNTER_WIDTH-1:0] MAX = MAX_COUNT[COUNTER_WIDTH-1:0];

    state_t state;
    logic   tick;
    logic   step_up;
    logic   step_dn;
    logic   at_max;
    logic   at_min;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(.DIV_WIDTH(PRESCALE_WIDTH)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr | load),
        .en   (state != IDLE),
        .div  (presc),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign step_up = (state == UP) && tick;
    assign step_dn = (state == DOWN) && tick;
    assign at_max  = (count == MAX);
    assign at_min  = (count == '0);
    assign state_o = state;

    // state follows act/direction every cycle; count obeys clr > load > step, flags mark boundary steps
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            ovflow <= 1'b0;
            unflow <= 1'b0;
        end else begin
            state  <= !act ? IDLE : (up_dwn_n ? UP : DOWN);
            ovflow <= 1'b0;
            unflow <= 1'b0;
            if (clr)
                count <= '0;
            else if (load)
                count <= (load_val > MAX) ? MAX : load_val;
            else if (step_up) begin
                count  <= at_max ? (SATURATE ? MAX : '0) : count + 1'b1;
                ovflow <= at_max;
            end else if (step_dn) begin
                count  <= at_min ? (SATURATE ? '0 : MAX) : count - 1'b1;
                unflow <= at_min;
            end
        end
    end
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed checks of three counter configurations sharing one stimulus stream
module tb_updown_mod_counter;
    logic       clk = 1'b0;
    logic       rst, act, up_dwn_n, load, clr;
    logic [3:0] load_val;
`ifdef COUNTER_PRESCALE_EN
    logic [3:0] presc;
`endif
    logic [3:0] c15, c9, cs;
    logic       o15, o9, os, u15, u9, us;
    logic [1:0] s15, s9, ss;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.COUNTER_WIDTH(4), .MAX_COUNT(15), .SATURATE(1'b0)) d15 (
        .clk(clk), .rst(rst), .act(act), .up_dwn_n(up_dwn_n), .load(load), .load_val(load_val), .clr(clr),
`ifdef COUNTER_PRESCALE_EN
        .presc(presc),
`endif
        .count(c15), .ovflow(o15), .unflow(u15), .state_o(s15));

    updown_mod_counter #(.COUNTER_WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) d9 (
        .clk(clk), .rst(rst), .act(act), .up_dwn_n(up_dwn_n), .load(load), .load_val(load_val), .clr(clr),
`ifdef COUNTER_PRESCALE_EN
        .presc(presc),
`endif
        .count(c9), .ovflow(o9), .unflow(u9), .state_o(s9));

    updown_mod_counter #(.COUNTER_WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) ds9 (
        .clk(clk), .rst(rst), .act(act), .up_dwn_n(up_dwn_n), .load(load), .load_val(load_val), .clr(clr),
`ifdef COUNTER_PRESCALE_EN
        .presc(presc),
`endif
        .count(cs), .ovflow(os), .unflow(us), .state_o(ss));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; act = 1'b1; up_dwn_n = 1'b1; load = 1'b1; load_val = 4'd5; clr = 1'b0;
`ifdef COUNTER_PRESCALE_EN
        presc = 4'd0;
`endif
        step(); step();
        chk("rst_count", c15, 0);
        chk("rst_state", s15, 0);
        chk("rst_ov", o15, 0);
        chk("rst_un", u15, 0);
        chk("rst_count9", c9, 0);

        rst = 1'b0; act = 1'b0; load = 1'b1; load_val = 4'd14;
        step();
        chk("ld14_c15", c15, 14);
        chk("ld14_clip9", c9, 9);
        chk("ld14_state", s15, 0);

        load = 1'b0; act = 1'b1; up_dwn_n = 1'b1;
        step();
        chk("up_lat_c15", c15, 14);
        chk("up_lat_state", s15, 1);
        step();
        chk("up_c15", c15, 15);
        chk("up_ov15_lo", o15, 0);
        chk("wrap9_c", c9, 0);
        chk("wrap9_ov", o9, 1);
        chk("sat_c1", cs, 9);
        chk("sat_ov1", os, 1);
        step();
        chk("wrap15_c", c15, 0);
        chk("wrap15_ov", o15, 1);
        chk("wrap15_un", u15, 0);
        chk("sat_c2", cs, 9);
        chk("sat_ov2", os, 1);
        step();
        chk("post_c15", c15, 1);
        chk("post_ov15", o15, 0);
        chk("post_c9", c9, 2);
        chk("sat_c3", cs, 9);
        chk("sat_ov3", os, 1);

        act = 1'b0; load = 1'b1; load_val = 4'd1;
        step();
        chk("ld1_c15", c15, 1);
        chk("ld1_ov_s", os, 0);
        chk("ld1_state", s15, 0);

        load = 1'b0; act = 1'b1; up_dwn_n = 1'b0;
        step();
        chk("dn_lat_state", s9, 2);
        chk("dn_lat_c9", c9, 1);
        step();
        chk("dn_c9", c9, 0);
        chk("dn_un9_lo", u9, 0);
        step();
        chk("unwrap9_c", c9, 9);
        chk("unwrap9_un", u9, 1);
        chk("unwrap9_ov", o9, 0);
        chk("unwrap15_c", c15, 15);
        chk("satdn_c", cs, 0);
        chk("satdn_un", us, 1);
        step();
        chk("dn2_c9", c9, 8);
        chk("dn2_un9", u9, 0);
        chk("satdn2_un", us, 1);

        load = 1'b1; load_val = 4'd12;
        step();
        chk("ld12_clip9", c9, 9);
        chk("ld12_c15", c15, 12);
        chk("ld12_un", u9, 0);

        load_val = 4'd4; up_dwn_n = 1'b1;
        step();
        chk("ld4_c15", c15, 4);
        load = 1'b0;
        step();
        chk("at5_c15", c15, 5);
        clr = 1'b1; load = 1'b1; load_val = 4'd7; up_dwn_n = 1'b0;
        step();
        chk("clr_pri_c15", c15, 0);
        chk("clr_ov", o15, 0);
        chk("clr_state", s15, 2);
        clr = 1'b0; load = 1'b0;
        step();
        chk("clr_un_c15", c15, 15);
        chk("clr_un15", u15, 1);

`ifdef COUNTER_PRESCALE_EN
        rst = 1'b1; act = 1'b0; up_dwn_n = 1'b1; presc = 4'd3;
        step();
        rst = 1'b0; act = 1'b1;
        step();
        for (int i = 1; i <= 12; i++) begin
            step();
            chk($sformatf("presc_e%0d", i), c15, i / 4);
        end
        step(); step();
        act = 1'b0;
        step();
        chk("presc_hold", c15, 3);
        act = 1'b1;
        step();
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("presc_rst_e%0d", i), c15, 3);
        end
        step();
        chk("presc_restart", c15, 4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
